// File: rtl/rgb_sched_pkg.sv
// rgb_sched_pkg: state encoding, colour indices and the colour-rotation helper shared by rgb_fade_scheduler.
package rgb_sched_pkg;
    typedef enum logic [2:0] {IDLE, RAMP_UP, HOLD, RAMP_DOWN, GAP} state_t;
    localparam logic [1:0] COLOR_RED = 2'd0;
    localparam logic [1:0] COLOR_GREEN = 2'd1;
    localparam logic [1:0] COLOR_BLUE = 2'd2;
    // First set mask bit after cur, wrapping blue->red; returns cur when it is the only candidate.
    function automatic logic [1:0] next_color(input logic [2:0] mask, input logic [1:0] cur);
        logic [1:0] c;
        logic found;
        next_color = cur;
        c = cur;
        found = 1'b0;
        for (int i = 0; i < 3; i++) begin
            c = (c == COLOR_BLUE) ? COLOR_RED : c + 2'd1;
            if (mask[c] && !found) begin
                next_color = c;
                found = 1'b1;
            end
        end
    endfunction
endpackage

// File: rtl/rgb_pwm_out.sv
// rgb_pwm_out: free-running PWM comparator driving the three active-low LED pins.
// With GAMMA_EN defined the duty is level squared (upper half), costing one extra clock of latency.
module rgb_pwm_out
    import rgb_sched_pkg::*;
#(
    parameter int LEVEL_BITS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [LEVEL_BITS-1:0] level,
    input  logic [1:0]            color_idx,
    output logic                  pwm_red,
    output logic                  pwm_green,
    output logic                  pwm_blue
);
    logic [LEVEL_BITS-1:0] cnt, duty;
    logic lit;
`ifdef GAMMA_EN
    logic [2*LEVEL_BITS-1:0] sq;
    assign sq = {{LEVEL_BITS{1'b0}}, level} * {{LEVEL_BITS{1'b0}}, level};
    always_ff @(posedge clk or posedge rst)
        if (rst)
            duty <= '0;
        else
            duty <= LEVEL_BITS'(sq >> LEVEL_BITS);
`else
    assign duty = level;
`endif
    assign lit = cnt < duty;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            cnt <= '0;
            pwm_red <= 1'b1;
            pwm_green <= 1'b1;
            pwm_blue <= 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
            pwm_red <= !(lit && color_idx == COLOR_RED);
            pwm_green <= !(lit && color_idx == COLOR_GREEN);
            pwm_blue <= !(lit && color_idx == COLOR_BLUE);
        end
endmodule

// File: rtl/rgb_fade_scheduler.sv
// rgb_fade_scheduler: fades the enabled RGB LED colours in turn through one shared up/hold/down envelope.
// Define GAMMA_EN for a squared (perceptual) PWM duty; envelope timing is unchanged.
module rgb_fade_scheduler
    import rgb_sched_pkg::*;
#(
    parameter int LEVEL_BITS = 8,
    parameter int STEP_DIV = 16,
    parameter int HOLD_STEPS = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [LEVEL_BITS-1:0] cmd_peak,
    input  logic [2:0]            cmd_mask,
    output logic                  pwm_red,
    output logic                  pwm_green,
    output logic                  pwm_blue,
    output logic                  busy,
    output logic [1:0]            color_idx,
    output logic                  cycle_done
);
    localparam int PW = STEP_DIV > 1 ? $clog2(STEP_DIV) : 1;
    localparam int HW = HOLD_STEPS > 1 ? $clog2(HOLD_STEPS) : 1;
    state_t state, state_n;
    logic [LEVEL_BITS-1:0] level, level_n, peak;
    logic [PW-1:0] presc;
    logic [HW-1:0] hold_cnt, hold_n;
    logic [2:0] mask;
    logic [1:0] color_n;
    logic en_q, tick, load;

    assign tick = presc == PW'(STEP_DIV - 1);
    assign cmd_ready = state == IDLE || (state == GAP && !tick);
    assign load = cmd_valid && cmd_ready;
    assign busy = state != IDLE;

    // Aborts use the registered enable so a drop coinciding with a tick lets that tick's step complete.
    always_comb begin
        state_n = state;
        level_n = level;
        hold_n = hold_cnt;
        color_n = color_idx;
        case (state)
            IDLE: begin
                level_n = '0;
                color_n = mask[color_idx] ? color_idx : next_color(mask, COLOR_BLUE);
                state_n = enable ? RAMP_UP : IDLE;
            end
            RAMP_UP: if (tick) begin
                if (!en_q)
                    state_n = RAMP_DOWN;
                else if (level == peak) begin
                    state_n = HOLD;
                    hold_n = '0;
                end else
                    level_n = level + 1'b1;
            end
            HOLD: if (tick) begin
                hold_n = hold_cnt + 1'b1;
                state_n = (!en_q || hold_cnt == HW'(HOLD_STEPS - 1)) ? RAMP_DOWN : HOLD;
            end
            RAMP_DOWN: if (tick) begin
                state_n = level == '0 ? GAP : RAMP_DOWN;
                level_n = level == '0 ? level : level - 1'b1;
            end
            GAP: if (tick) begin
                color_n = next_color(mask, color_idx);
                state_n = enable ? RAMP_UP : IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= IDLE;
            level <= '0;
            presc <= '0;
            hold_cnt <= '0;
            peak <= '1;
            mask <= 3'b111;
            color_idx <= COLOR_RED;
            cycle_done <= 1'b0;
            en_q <= 1'b0;
        end else begin
            state <= state_n;
            level <= level_n;
            hold_cnt <= hold_n;
            color_idx <= color_n;
            presc <= (state == IDLE || tick) ? '0 : presc + 1'b1;
            cycle_done <= state == GAP && tick;
            en_q <= enable;
            if (load) begin
                peak <= cmd_peak;
                mask <= cmd_mask == 3'b000 ? 3'b111 : cmd_mask;
            end
        end

    rgb_pwm_out #(.LEVEL_BITS(LEVEL_BITS)) u_pwm (
        .clk(clk),
        .rst(rst),
        .level(level),
        .color_idx(color_idx),
        .pwm_red(pwm_red),
        .pwm_green(pwm_green),
        .pwm_blue(pwm_blue)
    );
endmodule
